// File: rtl/adc_frame_packer_pkg.sv
// adc_frame_packer_pkg: shared constants, FSM state codes and frame-size helpers
// for the ADC frame packer. Optional checksum word is enabled by defining
// ADC_FRAME_PACKER_CHECKSUM_EN.
package adc_frame_packer_pkg;

`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // FSM state encoding (plain constants keep older tools happy)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_TS   = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CSUM = 3'd4;

  // Header field positions
  localparam int HDR_ID_LSB   = 56;
  localparam int HDR_SEQ_LSB  = 48;
  localparam int HDR_CNT_LSB  = 32;
  localparam int HDR_MASK_LSB = 0;

  // Data word layout: three 18-bit slots plus a data-word index byte on top
  localparam int CH_PER_WORD = 3;
  localparam int SLOT_W      = 18;
  localparam int DIDX_LSB    = 56;

  function automatic int data_words(input int num_ch);
    return (num_ch + CH_PER_WORD - 1) / CH_PER_WORD;
  endfunction

  // Header + timestamp + data words (+ checksum word when enabled)
  function automatic int words_per_frame(input int num_ch, input bit csum);
    return data_words(num_ch) + 2 + (csum ? 1 : 0);
  endfunction

endpackage

// File: rtl/adc_frame_packer_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones. A clear has
// priority over a coincident increment.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  // Count up until saturated; reset and clear both zero the count
  always_ff @(posedge clk) begin
    if (rst || clr_i)
      cnt_q <= '0;
    else if (inc_i && (cnt_q != 32'hFFFF_FFFF))
      cnt_q <= cnt_q + 32'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: turns each ADC sample set into one framed 64-bit stream
// packet (header, timestamp, packed channel words). One sample set can wait in
// a pending register while a frame is being sent; further ones are dropped and
// counted. Define ADC_FRAME_PACKER_CHECKSUM_EN to append an XOR checksum word.
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int          NUM_CH = 16,
  parameter int          WIDTH  = 18,
  parameter logic [7:0]  ID     = 8'hA1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    clear_counters,
  input  logic                    in_valid,
  input  logic [63:0]             in_ts,
  input  logic [NUM_CH-1:0]       in_ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [63:0]             out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic                    busy,
  output logic [31:0]             frame_count,
  output logic [31:0]             drop_count
);

  localparam int D     = data_words(NUM_CH);
  localparam int WPF   = words_per_frame(NUM_CH, CSUM_EN);
  localparam int NSLOT = D * CH_PER_WORD;

  state_t state_q, state_d;
  logic [2:0] dw_q, dw_d;
  logic [7:0] seq_q;

  logic                    pend_full_q;
  logic [63:0]             pend_ts_q,   wk_ts_q;
  logic [NUM_CH-1:0]       pend_mask_q, wk_mask_q;
  logic [NUM_CH*WIDTH-1:0] pend_data_q, wk_data_q;

  logic fire, last_word, last_fire, take, cap, drop;

  assign fire      = out_tvalid & out_tready;
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
  assign last_word = (state_q == ST_CSUM);
`else
  assign last_word = (state_q == ST_DATA) && (dw_q == 3'(D - 1));
`endif
  assign last_fire = fire & last_word;
  // Pending moves to the working register when idle or as the final word goes
  assign take      = pend_full_q & ((state_q == ST_IDLE) | last_fire);
  assign cap       = in_valid & ena & (~pend_full_q | take);
  assign drop      = in_valid & ena & pend_full_q & ~take;

  // Next-state: words advance only on an accepted beat
  always_comb begin
    state_d = state_q;
    dw_d    = dw_q;
    case (state_q)
      ST_IDLE: if (pend_full_q) state_d = ST_HDR;
      ST_HDR:  if (fire) state_d = ST_TS;
      ST_TS:   if (fire) begin
        state_d = ST_DATA;
        dw_d    = '0;
      end
      ST_DATA: if (fire) begin
        if (dw_q == 3'(D - 1)) begin
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = pend_full_q ? ST_HDR : ST_IDLE;
`endif
        end else begin
          dw_d = dw_q + 3'd1;
        end
      end
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
      ST_CSUM: if (fire) state_d = pend_full_q ? ST_HDR : ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, data-word index and wrapping sequence number
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dw_q    <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      dw_q    <= dw_d;
      if (last_fire) seq_q <= seq_q + 8'd1;
    end
  end

  // Pending-register occupancy
  always_ff @(posedge clk) begin
    if (rst)
      pend_full_q <= 1'b0;
    else if (cap)
      pend_full_q <= 1'b1;
    else if (take)
      pend_full_q <= 1'b0;
  end

  // Pending and working payloads; contents only matter while flagged full/busy
  always_ff @(posedge clk) begin
    if (cap) begin
      pend_ts_q   <= in_ts;
      pend_mask_q <= in_ch_valid;
      pend_data_q <= in_data;
    end
    if (take) begin
      wk_ts_q   <= pend_ts_q;
      wk_mask_q <= pend_mask_q;
      wk_data_q <= pend_data_q;
    end
  end

  // Sign-extend every channel into an 18-bit slot; slots past NUM_CH are zero
  logic [NSLOT-1:0][SLOT_W-1:0] slot;
  logic [D-1:0][63:0]           dword;

  for (genvar c = 0; c < NSLOT; c++) begin : g_slot
    if (c < NUM_CH) begin : g_ch
      logic signed [WIDTH-1:0] raw;
      assign raw     = wk_data_q[c*WIDTH +: WIDTH];
      assign slot[c] = SLOT_W'(raw);
    end else begin : g_pad
      assign slot[c] = '0;
    end
  end

  for (genvar d = 0; d < D; d++) begin : g_dword
    assign dword[d] = {8'(d), 2'b00, slot[3*d+2], slot[3*d+1], slot[3*d]};
  end

  logic [63:0] hdr_word;
  assign hdr_word = {ID, seq_q, 16'(WPF), 32'(wk_mask_q)};

`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
  logic [63:0] csum_q;

  // Running XOR of the words already accepted in this frame
  always_ff @(posedge clk) begin
    if (rst || take)
      csum_q <= '0;
    else if (fire)
      csum_q <= csum_q ^ out_tdata;
  end
`endif

  // Output word is a pure function of held state, so it is stable under stall
  always_comb begin
    out_tdata = '0;
    case (state_q)
      ST_HDR:  out_tdata = hdr_word;
      ST_TS:   out_tdata = wk_ts_q;
      ST_DATA: out_tdata = dword[dw_q];
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
      ST_CSUM: out_tdata = csum_q;
`endif
      default: out_tdata = '0;
    endcase
  end

  assign out_tvalid = (state_q != ST_IDLE);
  assign out_tlast  = last_word;
  assign busy       = (state_q != ST_IDLE) | pend_full_q;

  sat_counter32 u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear_counters),
    .inc_i (last_fire),
    .cnt_o (frame_count)
  );

  sat_counter32 u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear_counters),
    .inc_i (drop),
    .cnt_o (drop_count)
  );

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer (default NUM_CH=16, WIDTH=18).
module tb_adc_frame_packer;

  localparam int NCH = 16;
  localparam int W   = 18;
  localparam int ND  = 6;
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
  localparam int NW  = 9;
`else
  localparam int NW  = 8;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b1;
  logic              clear_counters = 1'b0;
  logic              in_valid = 1'b0;
  logic [63:0]       in_ts = '0;
  logic [NCH-1:0]    in_ch_valid = '0;
  logic [NCH*W-1:0]  in_data = '0;
  logic [63:0]       out_tdata;
  logic              out_tvalid, out_tlast;
  logic              out_tready = 1'b1;
  logic              busy;
  logic [31:0]       frame_count, drop_count;

  adc_frame_packer #(.NUM_CH(NCH), .WIDTH(W), .ID(8'hA1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clear_counters(clear_counters),
    .in_valid(in_valid), .in_ts(in_ts), .in_ch_valid(in_ch_valid), .in_data(in_data),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready), .busy(busy),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [64:0] exp_q[$];
  logic [7:0]  exp_seq = '0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] dword(input logic [NCH*W-1:0] dat, input int d);
    logic [63:0] w;
    w = '0;
    w[63:56] = d[7:0];
    for (int s = 0; s < 3; s++)
      if (3*d + s < NCH) w[s*18 +: 18] = dat[(3*d+s)*W +: W];
    return w;
  endfunction

  // Push one expected frame; 'hand' substitutes hand-computed words for the ramp case
  task automatic exp_frame(input logic [7:0] sq, input logic [63:0] ts,
                           input logic [15:0] mask, input logic [NCH*W-1:0] dat,
                           input bit hand);
    logic [63:0] fr[NW];
    logic [63:0] x;
    fr[0] = {8'hA1, sq, 16'(NW), 16'h0000, mask};
    fr[1] = ts;
    for (int d = 0; d < ND; d++) fr[2+d] = dword(dat, d);
    if (hand) begin
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
      fr[0] = 64'hA100_0009_0000_FFFF;
`else
      fr[0] = 64'hA100_0008_0000_FFFF;
`endif
      fr[2] = {8'h00, 2'b00, 18'd3, 18'd2, 18'd1};
      fr[7] = {8'h05, 38'b0, 18'd16};
    end
`ifdef ADC_FRAME_PACKER_CHECKSUM_EN
    x = '0;
    for (int i = 0; i < NW-1; i++) x = x ^ fr[i];
    fr[NW-1] = x;
`endif
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW-1), fr[i]});
  endtask

  task automatic send(input logic [63:0] ts, input logic [15:0] mask, input logic [NCH*W-1:0] dat);
    in_valid = 1'b1; in_ts = ts; in_ch_valid = mask; in_data = dat;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin tick(); n++; end
    if (n >= 4000) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s: drain timeout, %0d words outstanding, expected 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_free();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      vec_cnt++; err_cnt++;
      $display("FAIL wait_free: busy stuck at 1, expected 0");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    exp_q.delete();
    exp_seq = '0;
  endtask

  function automatic logic [NCH*W-1:0] rand_data();
    logic [NCH*W-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*W +: W] = 18'($urandom);
    return r;
  endfunction

  // Monitor: checks hold-under-stall and pops the scoreboard on each accepted beat
  initial begin
    logic        stall_prev;
    logic [64:0] held, e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          chk("hold_valid", 65'(out_tvalid), 65'd1);
          chk("hold_word", {out_tlast, out_tdata}, held);
        end
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL word: got unexpected %h expected none", {out_tlast, out_tdata});
          end else begin
            e = exp_q.pop_front();
            chk("word", {out_tlast, out_tdata}, e);
          end
          stall_prev = 1'b0;
        end else if (out_tvalid) begin
          stall_prev = 1'b1;
          held = {out_tlast, out_tdata};
        end else stall_prev = 1'b0;
      end
    end
  end

  // Pseudo-random downstream ready
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [NCH*W-1:0] ramp, da, db, dc;
    int n;
    for (int k = 0; k < NCH; k++) ramp[k*W +: W] = 18'(k + 1);

    // Reset state
    tick(); tick();
    chk("rst_tvalid", 65'(out_tvalid), 65'd0);
    chk("rst_tlast",  65'(out_tlast),  65'd0);
    chk("rst_tdata",  65'(out_tdata),  65'd0);
    chk("rst_busy",   65'(busy),       65'd0);
    chk("rst_frames", 65'(frame_count), 65'd0);
    chk("rst_drops",  65'(drop_count),  65'd0);
    rst = 1'b0;
    tick();

    // Single sample with hand-computed words, plus latency
    exp_frame(8'h00, 64'h0123_4567_89AB_CDEF, 16'hFFFF, ramp, 1'b1);
    exp_seq = 8'h01;
    send(64'h0123_4567_89AB_CDEF, 16'hFFFF, ramp);
    chk("lat_t1", 65'(out_tvalid), 65'd0);
    tick();
    chk("lat_t2", 65'(out_tvalid), 65'd1);
    drain("single");
    chk("single_frames", 65'(frame_count), 65'd1);
    chk("single_drops",  65'(drop_count),  65'd0);

    // in_valid with ena low is ignored
    ena = 1'b0;
    send(64'h55, 16'h1, ramp);
    tick(); tick();
    chk("ena0_busy",  65'(busy),       65'd0);
    chk("ena0_drops", 65'(drop_count), 65'd0);
    ena = 1'b1;

    // Three consecutive strobes: two frames back-to-back, one drop
    do_reset();
    da = rand_data(); db = rand_data(); dc = rand_data();
    exp_frame(8'h00, 64'hA, 16'h00FF, da, 1'b0);
    exp_frame(8'h01, 64'hB, 16'hFF00, db, 1'b0);
    exp_seq = 8'h02;
    in_valid = 1'b1; in_ts = 64'hA; in_ch_valid = 16'h00FF; in_data = da; tick();
    in_ts = 64'hB; in_ch_valid = 16'hFF00; in_data = db; tick();
    in_ts = 64'hC; in_ch_valid = 16'h0F0F; in_data = dc; tick();
    in_valid = 1'b0;
    drain("drop");
    chk("drop_drops",  65'(drop_count),  65'd1);
    chk("drop_frames", 65'(frame_count), 65'd2);

    // clear_counters zeroes counters but leaves seq running
    clear_counters = 1'b1; tick(); clear_counters = 1'b0;
    chk("clr_frames", 65'(frame_count), 65'd0);
    chk("clr_drops",  65'(drop_count),  65'd0);
    da = rand_data();
    exp_frame(exp_seq, 64'hD, 16'h1234, da, 1'b0);
    exp_seq++;
    send(64'hD, 16'h1234, da);
    drain("clr");
    chk("clr_frames2", 65'(frame_count), 65'd1);

    // Backpressure over 100 frames
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      wait_free();
      da = rand_data();
      exp_frame(exp_seq, {32'(f), 32'hFACE}, 16'($urandom), da, 1'b0);
      send({32'(f), 32'hFACE}, exp_q[exp_q.size()-NW][15:0], da);
      exp_seq++;
    end
    drain("bp");
    rand_rdy = 1'b0;
    tick();
    out_tready = 1'b1;
    chk("bp_drops",  65'(drop_count),  65'd0);
    chk("bp_frames", 65'(frame_count), 65'd100);

    // Sequence wrap over 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      wait_free();
      exp_frame(exp_seq, 64'(f), 16'hFFFF, ramp, 1'b0);
      send(64'(f), 16'hFFFF, ramp);
      exp_seq++;
    end
    drain("wrap");
    chk("wrap_frames", 65'(frame_count), 65'd257);

    // Reset during word 3
    out_tready = 1'b0;
    exp_frame(exp_seq, 64'h77, 16'hFFFF, ramp, 1'b0);
    send(64'h77, 16'hFFFF, ramp);
    n = 0;
    while (!out_tvalid && n < 20) begin tick(); n++; end
    chk("rstmid_start", 65'(out_tvalid), 65'd1);
    out_tready = 1'b1;
    tick(); tick(); tick();
    out_tready = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_tvalid", 65'(out_tvalid), 65'd0);
    chk("rstmid_frames", 65'(frame_count), 65'd0);
    chk("rstmid_busy",   65'(busy),        65'd0);
    out_tready = 1'b1;
    exp_seq = 8'h00;
    exp_frame(8'h00, 64'h0123_4567_89AB_CDEF, 16'hFFFF, ramp, 1'b1);
    send(64'h0123_4567_89AB_CDEF, 16'hFFFF, ramp);
    drain("rstmid_after");
    chk("rstmid_frames2", 65'(frame_count), 65'd1);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
